// File: rtl/gm_fifo_pkg.sv
// Shared types and pointer helpers for the dual-clock FIFO.
// Pointer helpers work on 32-bit containers with an explicit width, so one
// package serves every FIFO depth.
package gm_fifo_pkg;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_e;

    // Modulo subtraction of two w-bit pointers; result masked to w bits.
    function automatic logic [31:0] ptr_diff(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input int          w);
        logic [31:0] mask;
        mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (a - b) & mask;
    endfunction

    // Binary to gray, used before crossing a pointer into the other domain.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Gray to binary, used after the synchronizer in the receiving domain.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gm_fifo_rd_ctrl_if.sv
// Valid/ready output stream of the FIFO read controller.
// master drives data and valid; slave drives ready.
interface gm_fifo_rd_ctrl_if #(
    parameter int FIFO_WIDTH_OUT = 128
);
    logic [FIFO_WIDTH_OUT-1:0] out_data;
    logic                      out_valid;
    logic                      out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/gm_rd_skid_buf.sv
// Two-entry show-ahead buffer absorbing the storage array read latency.
// The head entry is always presented; the tail only holds a line while the
// consumer stalls with a second read already in flight.
module gm_rd_skid_buf #(
    parameter int WIDTH = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             valid,
    output logic [1:0]       count
);
    import gm_fifo_pkg::*;

    buf_state_e       state;
    buf_state_e       state_next;
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] tail_q;

    // State register for the occupancy FSM.
    always_ff @(posedge clk) begin
        if (rst) state <= BUF_EMPTY;
        else     state <= state_next;
    end

    // Occupancy transitions on capture (push) and consume (pop).
    always_comb begin
        state_next = state;
        unique case (state)
            BUF_EMPTY: if (push) state_next = BUF_ONE;
            BUF_ONE: begin
                if (push && !pop)      state_next = BUF_TWO;
                else if (!push && pop) state_next = BUF_EMPTY;
            end
            BUF_TWO:   if (pop) state_next = BUF_ONE;
            default:   state_next = BUF_EMPTY;
        endcase
    end

    // Occupancy-derived outputs; valid comes straight from the state register.
    always_comb begin
        valid = (state != BUF_EMPTY);
        count = 2'd0;
        if (state == BUF_ONE) count = 2'd1;
        if (state == BUF_TWO) count = 2'd2;
    end

    // Entry storage: captured data lands at head when it becomes the front, else tail.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            unique case (state)
                BUF_EMPTY: if (push) head_q <= push_data;
                BUF_ONE: begin
                    if (push && pop)  head_q <= push_data;
                    else if (push)    tail_q <= push_data;
                end
                BUF_TWO:   if (pop) head_q <= tail_q;
                default:   ;
            endcase
        end
    end

    // A capture while full would overwrite a line; the issue rule prevents it.
    always_ff @(posedge clk) begin
        if (!rst) assert (!(push && state == BUF_TWO));
    end

    assign head_data = head_q;

endmodule

// File: rtl/gm_fifo_rd_ctrl.sv
// Read-side controller of the parallel-BRAM dual-clock FIFO.
// Issues line reads when a full line is available and the output buffer has
// room counting the read in flight; the read pointer moves at issue time.
module gm_fifo_rd_ctrl #(
    parameter  int BRAM_WIDTH     = 32,
    parameter  int FIFO_WIDTH_OUT = 128,
    parameter  int FIFO_DEPTH     = 32,
    localparam int RD_STEP        = FIFO_WIDTH_OUT / BRAM_WIDTH,
    localparam int AW             = $clog2(FIFO_DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [AW:0]               wr_ptr_sync,
    output logic [AW:0]               rd_ptr_out,
    output logic [AW-1:0]             rdaddr_out,
    input  logic [FIFO_WIDTH_OUT-1:0] bram_data_in,
    output logic                      empty,
    gm_fifo_rd_ctrl_if.master         out_if
);
    import gm_fifo_pkg::*;

    localparam int         PW   = AW + 1;
    localparam logic [AW:0] STEP  = PW'(RD_STEP);
    localparam logic [AW:0] DEPTH = PW'(FIFO_DEPTH);

    logic [AW:0] rd_ptr;
    logic [AW:0] avail;
    logic        inflight;
    logic        issue;
    logic        pop;
    logic [1:0]  count;
    logic [2:0]  occupancy;

    // Issue decision: whole line available and a buffer slot reserved for it.
    always_comb begin
        avail     = PW'(ptr_diff(32'(wr_ptr_sync), 32'(rd_ptr), PW));
        pop       = out_if.out_valid & out_if.out_ready;
        occupancy = 3'(count) + 3'(inflight) - 3'(pop);
        issue     = (avail >= STEP) && (occupancy < 3'd2);
    end

    // Read pointer advances by one line per issue, wrapping through the MSB.
    always_ff @(posedge clk) begin
        if (rst)        rd_ptr <= '0;
        else if (issue) rd_ptr <= rd_ptr + STEP;
    end

    // A read issued this edge returns data to be captured on the next edge.
    always_ff @(posedge clk) begin
        if (rst) inflight <= 1'b0;
        else     inflight <= issue;
    end

    // More words available than storage holds means a corrupted pointer.
    always_ff @(posedge clk) begin
        if (!rst) assert (avail <= DEPTH);
    end

    gm_rd_skid_buf #(
        .WIDTH (FIFO_WIDTH_OUT)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data (bram_data_in),
        .pop       (pop),
        .head_data (out_if.out_data),
        .valid     (out_if.out_valid),
        .count     (count)
    );

    assign rd_ptr_out = rd_ptr;
    assign rdaddr_out = rd_ptr[AW-1:0];
    assign empty      = (count == 2'd0) && !inflight;

endmodule

// File: tb/tb_gm_fifo_rd_ctrl.sv
// Directed bench for gm_fifo_rd_ctrl with a registered-read storage model
// and a scoreboard of lines written by the bench.
module tb_gm_fifo_rd_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic [5:0]   wr_ptr_sync;
    logic [5:0]   rd_ptr_out;
    logic [4:0]   rdaddr_out;
    logic [127:0] bram_data_in;
    logic         empty;

    gm_fifo_rd_ctrl_if #(.FIFO_WIDTH_OUT(128)) out_if ();

    gm_fifo_rd_ctrl #(
        .BRAM_WIDTH     (32),
        .FIFO_WIDTH_OUT (128),
        .FIFO_DEPTH     (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_ptr_sync  (wr_ptr_sync),
        .rd_ptr_out   (rd_ptr_out),
        .rdaddr_out   (rdaddr_out),
        .bram_data_in (bram_data_in),
        .empty        (empty),
        .out_if       (out_if)
    );

    always #5 clk = ~clk;

    logic [31:0]  mem [32];
    logic [4:0]   bram_addr_q = 5'd0;
    logic [127:0] sb_q [$];
    int           pass_count = 0;
    int           check_count = 0;
    int           pop_count = 0;
    logic [5:0]   wp = 6'd0;

    // Storage array model: address registered on the clock, data one cycle later.
    always @(posedge clk) bram_addr_q <= rdaddr_out;
    assign bram_data_in = {mem[bram_addr_q + 5'd3], mem[bram_addr_q + 5'd2],
                           mem[bram_addr_q + 5'd1], mem[bram_addr_q]};

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        check_count++;
        assert (observed === expected) begin
            pass_count++;
        end else begin
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [5:0] wptr, input logic rdy, input logic rs);
        wr_ptr_sync      = wptr;
        out_if.out_ready = rdy;
        rst              = rs;
    endtask

    task automatic pushLine();
        logic [4:0] base;
        base = wp[4:0];
        for (int i = 0; i < 4; i++) mem[base + 5'(i)] = $urandom;
        sb_q.push_back({mem[base + 5'd3], mem[base + 5'd2], mem[base + 5'd1], mem[base]});
        wp          = wp + 6'd4;
        wr_ptr_sync = wp;
    endtask

    task automatic scoreboardPop();
        logic [127:0] exp_line;
        if (out_if.out_valid && out_if.out_ready) begin
            if (sb_q.size() == 0) begin
                checkOutput("sb_unexpected_pop", 128'(out_if.out_valid), 128'd0);
            end else begin
                exp_line = sb_q.pop_front();
                checkOutput("sb_data", out_if.out_data, exp_line);
            end
            pop_count++;
        end
    endtask

    task automatic stepCycle();
        scoreboardPop();
        @(negedge clk);
    endtask

    task automatic drainAll();
        applyStimulus(wp, 1'b1, 1'b0);
        for (int i = 0; i < 16 && sb_q.size() != 0; i++) stepCycle();
        checkOutput("drain_done", 128'(sb_q.size()), 128'd0);
        stepCycle();
        applyStimulus(wp, 1'b0, 1'b0);
    endtask

    initial begin
        logic [5:0] exp_rd;
        logic [5:0] last_rd;
        int         lines_written;
        int         pop_base;
        int         bubbles;
        int         toggles;

        for (int i = 0; i < 32; i++) mem[i] = 32'd0;

        // Reset held with data apparently available
        applyStimulus(6'd8, 1'b0, 1'b1);
        repeat (3) begin
            stepCycle();
            checkOutput("rst_valid", 128'(out_if.out_valid), 128'd0);
            checkOutput("rst_rd_ptr", 128'(rd_ptr_out), 128'd0);
            checkOutput("rst_empty", 128'(empty), 128'd1);
        end
        applyStimulus(6'd8, 1'b0, 1'b0);
        stepCycle();
        checkOutput("rst_first_issue", 128'(rd_ptr_out), 128'd4);
        stepCycle();
        checkOutput("rst_first_capture", 128'(out_if.out_valid), 128'd1);

        // Reset the cycle after an issue: in-flight and buffered lines dropped
        applyStimulus(6'd0, 1'b0, 1'b1);
        stepCycle();
        checkOutput("midrst_valid", 128'(out_if.out_valid), 128'd0);
        checkOutput("midrst_rd_ptr", 128'(rd_ptr_out), 128'd0);
        checkOutput("midrst_empty", 128'(empty), 128'd1);
        stepCycle();
        checkOutput("midrst_discard", 128'(out_if.out_valid), 128'd0);
        applyStimulus(6'd0, 1'b0, 1'b0);
        stepCycle();

        // Single line
        pushLine();
        checkOutput("single_rdaddr", 128'(rdaddr_out), 128'd0);
        stepCycle();
        checkOutput("single_rd_ptr", 128'(rd_ptr_out), 128'd4);
        checkOutput("single_valid_lat", 128'(out_if.out_valid), 128'd0);
        stepCycle();
        checkOutput("single_valid", 128'(out_if.out_valid), 128'd1);
        checkOutput("single_data", out_if.out_data, sb_q[0]);
        applyStimulus(wp, 1'b1, 1'b0);
        stepCycle();
        checkOutput("single_after_pop", 128'(out_if.out_valid), 128'd0);
        checkOutput("single_empty", 128'(empty), 128'd1);
        applyStimulus(wp, 1'b0, 1'b0);

        // Partial line
        applyStimulus(wp + 6'd3, 1'b0, 1'b0);
        repeat (3) stepCycle();
        checkOutput("partial_rd_ptr", 128'(rd_ptr_out), 128'd4);
        checkOutput("partial_empty", 128'(empty), 128'd1);
        pushLine();
        stepCycle();
        checkOutput("partial_issue", 128'(rd_ptr_out), 128'd8);
        drainAll();
        checkOutput("partial_drained", 128'(empty), 128'd1);

        // Backpressure
        repeat (4) pushLine();
        repeat (3) stepCycle();
        checkOutput("bp_rd_ptr", 128'(rd_ptr_out), 128'd16);
        checkOutput("bp_valid", 128'(out_if.out_valid), 128'd1);
        checkOutput("bp_head", out_if.out_data, sb_q[0]);
        repeat (2) stepCycle();
        checkOutput("bp_rd_ptr_hold", 128'(rd_ptr_out), 128'd16);
        checkOutput("bp_head_frozen", out_if.out_data, sb_q[0]);
        applyStimulus(wp, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checkOutput("bp_pop_valid", 128'(out_if.out_valid), 128'd1);
            stepCycle();
        end
        checkOutput("bp_sb_empty", 128'(sb_q.size()), 128'd0);
        checkOutput("bp_valid_after", 128'(out_if.out_valid), 128'd0);

        // Wrap: stream 40 lines at full rate
        exp_rd        = rd_ptr_out;
        last_rd       = rd_ptr_out;
        lines_written = 0;
        pop_base      = pop_count;
        bubbles       = 0;
        toggles       = 0;
        for (int c = 0; c < 200 && (pop_count - pop_base) < 40; c++) begin
            if (lines_written < 40 && sb_q.size() < 8) begin
                pushLine();
                lines_written++;
            end
            stepCycle();
            if (rd_ptr_out != last_rd) begin
                exp_rd = exp_rd + 6'd4;
                checkOutput("wrap_rd_ptr", 128'(rd_ptr_out), 128'(exp_rd));
                checkOutput("wrap_rdaddr", 128'(rdaddr_out), 128'(exp_rd[4:0]));
                if (rd_ptr_out[5] != last_rd[5]) toggles++;
                last_rd = rd_ptr_out;
            end
            if ((pop_count - pop_base) > 0 && (pop_count - pop_base) < 40 && !out_if.out_valid)
                bubbles++;
        end
        checkOutput("wrap_pop_count", 128'(pop_count - pop_base), 128'd40);
        checkOutput("wrap_bubbles", 128'(bubbles), 128'd0);
        checkOutput("wrap_msb_toggles", 128'(toggles), 128'd5);
        checkOutput("wrap_final_rd_ptr", 128'(rd_ptr_out), 128'd56);
        stepCycle();
        checkOutput("wrap_empty", 128'(empty), 128'd1);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
